audio_rx_unit: RTL
==================

Name: audio_rx_unit

Overview:
- Audio capture path: receives I2S serial audio (BCLK/LRCK/SDATA) from an external ADC/codec.
- Deserializes each sample and buffers it in a small FIFO.
- Writes samples to external memory through a Ufi master write port, as a length-bounded DMA.
- Counterpart to the audio transmit DMA; driven by the same style of CSR fields (address, length, enable).

Parameters:
- pUsiBusWidth, 32, width of oMUfiAdrs.
- pUfiBusWidth, 16, Ufi data word width; one sample per word.
- pMemAdrsWidth, 19, width of DMA address/length and the internal word counter.
- pSamplingBitWidth, 8, captured sample resolution; must be <= pUfiBusWidth.
- pFifoDepth, 16, sample FIFO depth; power of two.

Ports:
- iSCLK  in  1  system clock; the only clock.
- iSRST  in  1  synchronous active-high reset.
- iAudioBclk  in  1  I2S bit clock, async, must be <= iSCLK/4.
- iAudioLrck  in  1  I2S word select, async; 0 = left.
- iAudioSdata  in  1  I2S serial data, async.
- oMUfiAdrs  out  pUsiBusWidth  write word address.
- oMUfiWd  out  pUfiBusWidth  write data.
- oMUfiWEd  out  1  write enable, asserted together with oMUfiVd.
- oMUfiVd  out  1  request valid.
- iMUfiRdy  in  1  bus can accept the request this cycle.
- iDmaAdrs  in  pMemAdrsWidth  base word address.
- iDmaLen  in  pMemAdrsWidth  number of words to write.
- iDmaEn  in  1  level enable from CSR.
- oDmaDone  out  1  transfer complete; held high.
- oOverrun  out  1  sticky: a sample was dropped because the FIFO was full.

Behaviour:
- Reset (iSRST=1 at a rising edge of iSCLK):
  - All outputs 0.
  - FSM in IDLE; FIFO empty; synchronizers cleared.
- Input synchronization and bit capture:
  - BCLK, LRCK and SDATA each pass through a 2-FF synchronizer, plus one more history stage for BCLK/LRCK.
  - A BCLK rising edge is detected as the synchronized value going 0->1.
  - SDATA and LRCK are sampled only on a BCLK rising edge.
- Framing (I2S format):
  - An LRCK transition seen at a BCLK rise starts a new word.
  - The MSB arrives at the following BCLK rise.
  - The first pSamplingBitWidth bits are shifted in MSB-first; extra bits are ignored.
  - Sample complete: the word had LRCK=0, all pSamplingBitWidth bits were captured, and FSM=RUN.
  - A short word (LRCK toggles before all bits arrive) is discarded.
- FIFO push:
  - A completed sample is pushed left-justified: sample in bits [pUfiBusWidth-1 -: pSamplingBitWidth], low bits 0.
  - If the FIFO is full, the sample is dropped and oOverrun is set to 1.
  - oOverrun stays 1 until the next DMA start.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN on an iDmaEn 0->1 edge. On entry: latch iDmaAdrs and iDmaLen, clear the counter, flush the FIFO, clear oOverrun.
  - IDLE -> DONE directly if the latched length is 0.
  - RUN -> DONE when word number len-1 is accepted (iMUfiRdy=1 while oMUfiVd=1).
  - RUN -> IDLE if iDmaEn falls. This aborts: oMUfiVd drops the next cycle, the FIFO is flushed, oDmaDone stays 0.
  - DONE: oDmaDone=1; capture stops.
  - DONE -> IDLE when iDmaEn=0; oDmaDone clears in the same transition.
- Ufi write handshake (valid/ready):
  - In RUN with the FIFO non-empty, registered oMUfiVd=oMUfiWEd=1 and oMUfiWd = FIFO head.
  - oMUfiAdrs = zero-extend((base + count) mod 2^pMemAdrsWidth); the address wraps inside the memory window.
  - Address and data are held stable until accepted.
  - On acceptance: pop the FIFO and increment count.
  - Back-to-back writes happen every cycle when the FIFO has data and iMUfiRdy stays 1.
  - A push and a pop in the same cycle are both honoured; FIFO occupancy is unchanged.
- Latency: last sample bit at a BCLK edge -> oMUfiVd high within 5 iSCLK cycles, provided the FIFO was empty and FSM=RUN.

Optional Feature:
- AUDIO_RX_STEREO_EN defined:
  - Both channels are captured, in order L, R, L, R …
  - Each channel consumes one word, so iDmaLen counts channel words.
  - The first word stored after a start is always a left sample; a right word completing before the first left word is discarded.
- Not defined: left channel only; right words are ignored.

Decomposition:
- Shared package audio_pkg:
  - FSM state enum (IDLE/RUN/DONE).
  - I2S channel constant (LEFT=0).
  - Function computing left-justified packing.
- One sub-module: audio_rx_fifo, a single-clock synchronous FIFO with flush, full and empty flags.
- The I2S deserializer and the DMA FSM stay in the top module.

Test Plan:
- Reset, iDmaLen=4, iDmaAdrs=0x100, iDmaEn rises; send left samples 0xA5, 0x3C, 0xFF, 0x01 with iMUfiRdy=1 -> writes 0xA500@0x100, 0x3C00@0x101, 0xFF00@0x102, 0x0100@0x103; oDmaDone=1.
- Hold iMUfiRdy=0 while 20 samples arrive (pFifoDepth=16) -> oOverrun=1; after release, exactly 16 writes of the first 16 samples, in order.
- iDmaAdrs=0x7FFFE, iDmaLen=4 -> addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- iDmaEn drops after 2 of 8 words -> oMUfiVd=0 the next cycle, oDmaDone stays 0; a restart with len=1 writes to the new base from an empty FIFO.
- iDmaLen=0 -> oDmaDone=1 with no oMUfiVd; iDmaEn=0 -> oDmaDone=0.
- Short word (LRCK toggles after 3 bits) -> no write; the next full word is written normally. With AUDIO_RX_STEREO_EN, L=0x11 and R=0x22 -> 0x1100 then 0x2200.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the I2S receive DMA (audio_rx_unit).
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } audio_state_e;

  localparam logic CH_LEFT = 1'b0;

  localparam int unsigned PACK_W = 32;

  // Moves a right-aligned sample to the top of a bus_w-wide word, low bits zero.
  function automatic logic [PACK_W-1:0] pack_left(input logic [PACK_W-1:0] sample,
                                                  input int unsigned samp_w,
                                                  input int unsigned bus_w);
    return sample << (bus_w - samp_w);
  endfunction

endpackage

// File: rtl/audio_rx_fifo.sv
// Single-clock sample FIFO with synchronous flush; the head word is readable
// without a pop so the write port can present it directly.
module audio_rx_fifo #(
  parameter int pDataWidth = 16,
  parameter int pDepth     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [pDataWidth-1:0] wr_data,
  input  logic                  rd_en,
  output logic [pDataWidth-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  empty_nxt
);

  localparam int AW = $clog2(pDepth);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [pDataWidth-1:0] mem_q [pDepth];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  wr_ok, rd_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  assign empty_nxt = (wr_ptr_d == rd_ptr_d);
  assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/audio_rx_unit.sv
// I2S capture into a sample FIFO, drained to memory as a length-bounded DMA.
// Define AUDIO_RX_STEREO_EN to capture L and R words; default is left only.
//
// state   | meaning
// IDLE    | waiting for a rising iDmaEn; capture disabled
// RUN     | capturing samples and writing them out
// DONE    | all words written; oDmaDone high until iDmaEn drops
module audio_rx_unit
  import audio_pkg::*;
#(
  parameter int pUsiBusWidth      = 32,
  parameter int pUfiBusWidth      = 16,
  parameter int pMemAdrsWidth     = 19,
  parameter int pSamplingBitWidth = 8,
  parameter int pFifoDepth        = 16
) (
  input  logic                     iSCLK,
  input  logic                     iSRST,
  input  logic                     iAudioBclk,
  input  logic                     iAudioLrck,
  input  logic                     iAudioSdata,
  output logic [pUsiBusWidth-1:0]  oMUfiAdrs,
  output logic [pUfiBusWidth-1:0]  oMUfiWd,
  output logic                     oMUfiWEd,
  output logic                     oMUfiVd,
  input  logic                     iMUfiRdy,
  input  logic [pMemAdrsWidth-1:0] iDmaAdrs,
  input  logic [pMemAdrsWidth-1:0] iDmaLen,
  input  logic                     iDmaEn,
  output logic                     oDmaDone,
  output logic                     oOverrun
);

  localparam int SW  = pSamplingBitWidth;
  localparam int BCW = $clog2(SW + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(SW - 1);
  localparam logic [BCW-1:0] BIT_FULL = BCW'(SW);
  localparam logic [BCW-1:0] BIT_ONE  = {{(BCW-1){1'b0}}, 1'b1};
  localparam logic [pMemAdrsWidth-1:0] ADR_ONE = {{(pMemAdrsWidth-1){1'b0}}, 1'b1};

  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrck_s1_q, lrck_s2_q;
  logic sdata_s1_q, sdata_s2_q;

  audio_state_e           state_q, state_d;
  logic                   en_q;
  logic [pMemAdrsWidth-1:0] base_q, base_d;
  logic [pMemAdrsWidth-1:0] len_q, len_d;
  logic [pMemAdrsWidth-1:0] count_q, count_d;
  logic                   vd_q, vd_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;
  logic                   lrck_hist_q, lrck_hist_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]          shift_q, shift_d;
  logic [SW:0]            shift_ext;

  logic bclk_rise, sample_done, ch_ok, push_req, start, fifo_flush, accept;
  logic fifo_full, fifo_empty, fifo_empty_nxt;
  logic [pUfiBusWidth-1:0] fifo_wdata, fifo_rdata;
  logic [pMemAdrsWidth-1:0] adr_mem;

  assign bclk_rise = bclk_s2_q && !bclk_s3_q;
  assign shift_ext = {shift_q, sdata_s2_q};

  // The rise that shows a new LRCK level only opens the word; the MSB follows.
  always_comb begin
    lrck_hist_d = lrck_hist_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sample_done = 1'b0;
    if (bclk_rise) begin
      if (lrck_s2_q != lrck_hist_q) begin
        lrck_hist_d = lrck_s2_q;
        bit_cnt_d   = '0;
        shift_d     = '0;
      end else if (bit_cnt_q != BIT_FULL) begin
        shift_d   = shift_ext[SW-1:0];
        bit_cnt_d = bit_cnt_q + BIT_ONE;
        if (bit_cnt_q == BIT_LAST) sample_done = 1'b1;
      end
    end
  end

  assign fifo_wdata = pUfiBusWidth'(pack_left(PACK_W'(shift_ext[SW-1:0]), SW, pUfiBusWidth));

`ifdef AUDIO_RX_STEREO_EN
  logic got_left_q, got_left_d;

  // Right words are only kept once a left word has opened the stream.
  assign ch_ok = (lrck_hist_q == CH_LEFT) || got_left_q;

  always_comb begin
    got_left_d = got_left_q;
    if (start) got_left_d = 1'b0;
    else if (push_req && (lrck_hist_q == CH_LEFT)) got_left_d = 1'b1;
  end

  always_ff @(posedge iSCLK) begin
    if (iSRST) got_left_q <= 1'b0;
    else       got_left_q <= got_left_d;
  end
`else
  assign ch_ok = (lrck_hist_q == CH_LEFT);
`endif

  assign push_req = sample_done && (state_q == ST_RUN) && ch_ok;
  assign accept   = vd_q && iMUfiRdy;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    ovr_d      = ovr_q;
    start      = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iDmaEn && !en_q) begin
          start      = 1'b1;
          fifo_flush = 1'b1;
          base_d     = iDmaAdrs;
          len_d      = iDmaLen;
          count_d    = '0;
          state_d    = (iDmaLen == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!iDmaEn) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else if (accept) begin
          count_d = count_q + ADR_ONE;
          if (count_q == len_q - ADR_ONE) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!iDmaEn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (push_req && fifo_full) ovr_d = 1'b1;
    if (start) ovr_d = 1'b0;
  end

  assign vd_d   = (state_d == ST_RUN) && !fifo_empty_nxt;
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_s3_q   <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      sdata_s1_q  <= 1'b0;
      sdata_s2_q  <= 1'b0;
      lrck_hist_q <= 1'b0;
      bit_cnt_q   <= BIT_FULL;
      shift_q     <= '0;
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      vd_q        <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      bclk_s1_q   <= iAudioBclk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_s3_q   <= bclk_s2_q;
      lrck_s1_q   <= iAudioLrck;
      lrck_s2_q   <= lrck_s1_q;
      sdata_s1_q  <= iAudioSdata;
      sdata_s2_q  <= sdata_s1_q;
      lrck_hist_q <= lrck_hist_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      state_q     <= state_d;
      en_q        <= iDmaEn;
      base_q      <= base_d;
      len_q       <= len_d;
      count_q     <= count_d;
      vd_q        <= vd_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  audio_rx_fifo #(
    .pDataWidth(pUfiBusWidth),
    .pDepth    (pFifoDepth)
  ) u_fifo (
    .clk      (iSCLK),
    .rst      (iSRST),
    .flush    (fifo_flush),
    .wr_en    (push_req),
    .wr_data  (fifo_wdata),
    .rd_en    (accept),
    .rd_data  (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .empty_nxt(fifo_empty_nxt)
  );

  // Address wraps inside the pMemAdrsWidth window before zero-extension.
  assign adr_mem   = base_q + count_q;
  assign oMUfiAdrs = vd_q ? {{(pUsiBusWidth-pMemAdrsWidth){1'b0}}, adr_mem} : '0;
  assign oMUfiWd   = (vd_q && !fifo_empty) ? fifo_rdata : '0;
  assign oMUfiVd   = vd_q;
  assign oMUfiWEd  = vd_q;
  assign oDmaDone  = done_q;
  assign oOverrun  = ovr_q;

endmodule
